// File: rtl/mag_peak_scanner.sv
// -----------------------------------------------------------------------------
// mag_peak_scanner
//   Initiator side of the magnitude LUT block. On a start request it walks one
//   frame of FFT bins held in a synchronous bin RAM, presents each bin's
//   real/imag words to the LUT block, captures the returned magnitude one cycle
//   later, streams (bin, mag) beats and reports the peak bin of the frame.
//
// Ports
//   clock          in   system clock, rising edge
//   reset          in   synchronous, active-high reset
//   start          in   1-cycle request to scan one frame (IDLE only)
//   busy           out  high while a frame is in flight
//   done           out  1-cycle pulse; peak_* valid and stable
//   bin_addr       out  bin RAM read address (holds outside SCAN)
//   bin_real       in   bin RAM real word, valid 1 cycle after bin_addr
//   bin_imag       in   bin RAM imag word, valid 1 cycle after bin_addr
//   mag_enable     out  LUT block enable
//   mag_addr_real  out  LUT block addr_real
//   mag_addr_cplx  out  LUT block addr_cplx
//   mag            in   LUT magnitude, valid the cycle after mag_enable
//   out_valid      out  stream beat qualifier
//   out_bin        out  bin index of beat
//   out_mag        out  magnitude of beat
//   peak_bin       out  bin of largest mag in last completed frame
//   peak_mag       out  largest mag in last completed frame
// -----------------------------------------------------------------------------
module mag_peak_scanner #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 256,
   parameter int NUM_BINS = 64,
   parameter int SKIP_DC  = 0,
   localparam int DEPTH_LOG = $clog2(DEPTH),
   localparam int BIN_LOG   = $clog2(NUM_BINS)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [BIN_LOG-1:0]   bin_addr,
   input  logic [DEPTH_LOG-1:0] bin_real,
   input  logic [DEPTH_LOG-1:0] bin_imag,
   output logic                 mag_enable,
   output logic [DEPTH_LOG-1:0] mag_addr_real,
   output logic [DEPTH_LOG-1:0] mag_addr_cplx,
   input  logic [WIDTH-1:0]     mag,
   output logic                 out_valid,
   output logic [BIN_LOG-1:0]   out_bin,
   output logic [WIDTH-1:0]     out_mag,
   output logic [BIN_LOG-1:0]   peak_bin,
   output logic [WIDTH-1:0]     peak_mag
);

   localparam bit SKIP_BIN0 = (SKIP_DC != 0);
   localparam logic [BIN_LOG-1:0] LAST_BIN = BIN_LOG'(NUM_BINS - 1);
   localparam logic [1:0] LAST_DRAIN = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN,
      DONE
   } state_t;

   state_t state, state_next;

   logic [BIN_LOG-1:0] scan_cnt;
   logic [1:0]         drain_cnt;
   logic               accept;
   logic               scan_last;
   logic               drain_last;

   // pipeline qualifiers and bin tags travelling alongside the data
   logic               addr_v;
   logic               rd_v;
   logic [BIN_LOG-1:0] rd_bin;
   logic [BIN_LOG-1:0] lut_bin;
   logic               samp_v;
   logic [BIN_LOG-1:0] samp_bin;

   logic [BIN_LOG-1:0] work_bin;
   logic [WIDTH-1:0]   work_mag;
   logic               peak_ok;

   assign scan_last  = (scan_cnt == LAST_BIN);
   assign drain_last = (drain_cnt == LAST_DRAIN);

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // done is registered off the DONE state, so the IDLE cycle carrying the
   // done pulse must also refuse start.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (start && !done) begin
               accept     = 1'b1;
               state_next = SCAN;
            end
         end
         SCAN: begin
            if (scan_last) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Frame counters (stop at their terminal value, never wrap mid-frame)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         scan_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         if (accept) begin
            scan_cnt <= '0;
         end else if (state == SCAN && !scan_last) begin
            scan_cnt <= scan_cnt + 1'b1;
         end

         if (state != DRAIN) begin
            drain_cnt <= '0;
         end else if (!drain_last) begin
            drain_cnt <= drain_cnt + 2'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Status outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         peak_bin <= '0;
         peak_mag <= '0;
      end else begin
         busy <= (state == SCAN) || (state == DRAIN);
         done <= (state == DONE);
         if (state == DONE) begin
            peak_bin <= work_bin;
            peak_mag <= work_mag;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Read pipeline: address -> RAM data -> LUT request -> mag sample -> beat
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         addr_v   <= 1'b0;
         bin_addr <= '0;
         rd_v     <= 1'b0;
         rd_bin   <= '0;
      end else begin
         addr_v <= (state == SCAN);
         if (state == SCAN) begin
            bin_addr <= scan_cnt;
         end
         rd_v <= addr_v;
         if (addr_v) begin
            rd_bin <= bin_addr;
         end
      end
   end

   // RAM words arrive in the cycle after the address, so they are captured
   // while rd_v is high.
   always_ff @(posedge clock) begin
      if (reset) begin
         mag_enable    <= 1'b0;
         mag_addr_real <= '0;
         mag_addr_cplx <= '0;
         lut_bin       <= '0;
      end else begin
         mag_enable <= rd_v;
         if (rd_v) begin
            mag_addr_real <= bin_real;
            mag_addr_cplx <= bin_imag;
            lut_bin       <= rd_bin;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         samp_v    <= 1'b0;
         samp_bin  <= '0;
         out_valid <= 1'b0;
         out_bin   <= '0;
         out_mag   <= '0;
      end else begin
         samp_v <= mag_enable;
         if (mag_enable) begin
            samp_bin <= lut_bin;
         end
         out_valid <= samp_v;
         if (samp_v) begin
            out_bin <= samp_bin;
            out_mag <= mag;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Working peak: strict compare keeps the lowest bin on ties
   // ---------------------------------------------------------------------------
   assign peak_ok = samp_v && !(SKIP_BIN0 && (samp_bin == '0)) && (mag > work_mag);

   always_ff @(posedge clock) begin
      if (reset) begin
         work_bin <= '0;
         work_mag <= '0;
      end else if (accept) begin
         work_bin <= '0;
         work_mag <= '0;
      end else if (peak_ok) begin
         work_bin <= samp_bin;
         work_mag <= mag;
      end
   end

endmodule

// File: tb/tb_mag_peak_scanner.sv
module tb_mag_peak_scanner;

   localparam int NB = 64;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset;
   logic start;

   // DUT 0: SKIP_DC = 0
   logic        busy0, done0, mag_enable0, out_valid0;
   logic [5:0]  bin_addr0, out_bin0, peak_bin0;
   logic [7:0]  bin_real0, bin_imag0, mag_addr_real0, mag_addr_cplx0;
   logic [15:0] mag0 = '0;
   logic [15:0] out_mag0, peak_mag0;

   // DUT 1: SKIP_DC = 1
   logic        busy1, done1, mag_enable1, out_valid1;
   logic [5:0]  bin_addr1, out_bin1, peak_bin1;
   logic [7:0]  bin_real1, bin_imag1, mag_addr_real1, mag_addr_cplx1;
   logic [15:0] mag1 = '0;
   logic [15:0] out_mag1, peak_mag1;

   logic [7:0] ram_re [NB];
   logic [7:0] ram_im [NB];

   int checks = 0;
   int errors = 0;

   int          held_pb0, held_pb1;
   logic [15:0] held_pm0, held_pm1;

   mag_peak_scanner #(.WIDTH(16), .DEPTH(256), .NUM_BINS(64), .SKIP_DC(0)) dut0 (
      .clock(clock), .reset(reset), .start(start), .busy(busy0), .done(done0),
      .bin_addr(bin_addr0), .bin_real(bin_real0), .bin_imag(bin_imag0),
      .mag_enable(mag_enable0), .mag_addr_real(mag_addr_real0),
      .mag_addr_cplx(mag_addr_cplx0), .mag(mag0), .out_valid(out_valid0),
      .out_bin(out_bin0), .out_mag(out_mag0), .peak_bin(peak_bin0), .peak_mag(peak_mag0)
   );

   mag_peak_scanner #(.WIDTH(16), .DEPTH(256), .NUM_BINS(64), .SKIP_DC(1)) dut1 (
      .clock(clock), .reset(reset), .start(start), .busy(busy1), .done(done1),
      .bin_addr(bin_addr1), .bin_real(bin_real1), .bin_imag(bin_imag1),
      .mag_enable(mag_enable1), .mag_addr_real(mag_addr_real1),
      .mag_addr_cplx(mag_addr_cplx1), .mag(mag1), .out_valid(out_valid1),
      .out_bin(out_bin1), .out_mag(out_mag1), .peak_bin(peak_bin1), .peak_mag(peak_mag1)
   );

   // behavioural 1-cycle bin RAM
   always @(posedge clock) begin
      bin_real0 <= ram_re[bin_addr0];
      bin_imag0 <= ram_im[bin_addr0];
      bin_real1 <= ram_re[bin_addr1];
      bin_imag1 <= ram_im[bin_addr1];
   end

   // behavioural 1-cycle LUT: mag = {addr_real, addr_cplx}, holds when idle
   always @(posedge clock) begin
      if (mag_enable0) mag0 <= {mag_addr_real0, mag_addr_cplx0};
      if (mag_enable1) mag1 <= {mag_addr_real1, mag_addr_cplx1};
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] bin_mag(input int k);
      return {ram_re[k], ram_im[k]};
   endfunction

   // peak = largest eligible magnitude, located at its first occurrence
   task automatic ref_peak(input bit skip, output int pb, output logic [15:0] pm);
      int first;
      pm = '0;
      first = skip ? 1 : 0;
      for (int k = first; k < NB; k++)
         if (bin_mag(k) > pm) pm = bin_mag(k);
      pb = 0;
      if (pm != 0) begin
         for (int k = NB - 1; k >= first; k--)
            if (bin_mag(k) == pm) pb = k;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " busy"}, 32'(busy0), 0);
      check({tag, " done"}, 32'(done0), 0);
      check({tag, " mag_enable"}, 32'(mag_enable0), 0);
      check({tag, " out_valid"}, 32'(out_valid0), 0);
      check({tag, " bin_addr"}, 32'(bin_addr0), 0);
      check({tag, " addr_real"}, 32'(mag_addr_real0), 0);
      check({tag, " addr_cplx"}, 32'(mag_addr_cplx0), 0);
      check({tag, " out_bin"}, 32'(out_bin0), 0);
      check({tag, " out_mag"}, 32'(out_mag0), 0);
      check({tag, " peak_bin"}, 32'(peak_bin0), 0);
      check({tag, " peak_mag"}, 32'(peak_mag0), 0);
      check({tag, " busy1"}, 32'(busy1), 0);
      check({tag, " done1"}, 32'(done1), 0);
      check({tag, " out_valid1"}, 32'(out_valid1), 0);
      check({tag, " peak_bin1"}, 32'(peak_bin1), 0);
      check({tag, " peak_mag1"}, 32'(peak_mag1), 0);
   endtask

   // Called at a falling edge. Raises start for one cycle, then checks every
   // cycle C0..C69 against the frame timeline; returns at the falling edge of C69.
   task automatic run_frame(input string name, input bit repulse);
      int          pb0, pb1;
      logic [15:0] pm0, pm1;
      bit          in_stream;
      ref_peak(1'b0, pb0, pm0);
      ref_peak(1'b1, pb1, pm1);
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int rel = 0; rel <= 69; rel++) begin
         if (rel > 0) @(negedge clock);
         start = repulse && (rel == 10 || rel == 69);
         in_stream = (rel >= 5 && rel <= 68);
         check($sformatf("%s c%0d busy", name, rel), 32'(busy0), 32'(rel >= 1 && rel <= 68));
         check($sformatf("%s c%0d busy1", name, rel), 32'(busy1), 32'(rel >= 1 && rel <= 68));
         check($sformatf("%s c%0d done", name, rel), 32'(done0), 32'(rel == 69));
         check($sformatf("%s c%0d done1", name, rel), 32'(done1), 32'(rel == 69));
         check($sformatf("%s c%0d mag_enable", name, rel), 32'(mag_enable0),
               32'(rel >= 3 && rel <= 66));
         if (rel >= 1 && rel <= 64)
            check($sformatf("%s c%0d bin_addr", name, rel), 32'(bin_addr0), 32'(rel - 1));
         check($sformatf("%s c%0d out_valid", name, rel), 32'(out_valid0), 32'(in_stream));
         check($sformatf("%s c%0d out_valid1", name, rel), 32'(out_valid1), 32'(in_stream));
         if (in_stream) begin
            check($sformatf("%s c%0d out_bin", name, rel), 32'(out_bin0), 32'(rel - 5));
            check($sformatf("%s c%0d out_mag", name, rel), 32'(out_mag0), 32'(bin_mag(rel - 5)));
            check($sformatf("%s c%0d out_bin1", name, rel), 32'(out_bin1), 32'(rel - 5));
            check($sformatf("%s c%0d out_mag1", name, rel), 32'(out_mag1), 32'(bin_mag(rel - 5)));
         end
         if (rel < 69) begin
            check($sformatf("%s c%0d peak_bin hold", name, rel), 32'(peak_bin0), 32'(held_pb0));
            check($sformatf("%s c%0d peak_mag hold", name, rel), 32'(peak_mag0), 32'(held_pm0));
            check($sformatf("%s c%0d peak_bin1 hold", name, rel), 32'(peak_bin1), 32'(held_pb1));
         end else begin
            check({name, " peak_bin"}, 32'(peak_bin0), 32'(pb0));
            check({name, " peak_mag"}, 32'(peak_mag0), 32'(pm0));
            check({name, " peak_bin skipdc"}, 32'(peak_bin1), 32'(pb1));
            check({name, " peak_mag skipdc"}, 32'(peak_mag1), 32'(pm1));
            held_pb0 = pb0;
            held_pm0 = pm0;
            held_pb1 = pb1;
            held_pm1 = pm1;
         end
      end
   endtask

   task automatic fill_const(input logic [7:0] re, input logic [7:0] im);
      for (int k = 0; k < NB; k++) begin
         ram_re[k] = re;
         ram_im[k] = im;
      end
   endtask

   task automatic fill_random(input int re_max, input int im_max);
      for (int k = 0; k < NB; k++) begin
         ram_re[k] = 8'($urandom_range(0, re_max));
         ram_im[k] = 8'($urandom_range(0, im_max));
      end
   endtask

   initial begin
      held_pb0 = 0;
      held_pm0 = '0;
      held_pb1 = 0;
      held_pm1 = '0;
      fill_const(8'h00, 8'h00);

      // reset held for 3 cycles with start high
      reset = 1'b1;
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check_all_zero($sformatf("reset%0d", i));
      end
      reset = 1'b0;
      start = 1'b0;
      @(negedge clock);
      check("post-reset busy", 32'(busy0), 0);

      // single dominant bin
      fill_const(8'h00, 8'h10);
      ram_re[17] = 8'h03;
      ram_im[17] = 8'h00;
      run_frame("bin17", 1'b0);

      // tie between bins 5 and 40 keeps the lower bin
      fill_const(8'h00, 8'h10);
      ram_re[5]  = 8'h02;
      ram_im[5]  = 8'h00;
      ram_re[40] = 8'h02;
      ram_im[40] = 8'h00;
      run_frame("tie", 1'b0);

      // start re-pulsed mid-scan and in the done cycle, then back-to-back frame
      fill_random(255, 255);
      run_frame("repulse", 1'b1);
      run_frame("chained", 1'b0);

      // reset in C30 aborts the frame
      fill_random(255, 255);
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (30) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_all_zero("abort");
      reset = 1'b0;
      held_pb0 = 0;
      held_pm0 = '0;
      held_pb1 = 0;
      held_pm1 = '0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clock);
         check($sformatf("abort c%0d out_valid", i), 32'(out_valid0), 0);
         check($sformatf("abort c%0d done", i), 32'(done0), 0);
         check($sformatf("abort c%0d busy", i), 32'(busy0), 0);
      end
      run_frame("after-abort", 1'b0);

      // DC bin is largest; SKIP_DC instance must pick bin 3 yet still stream bin 0
      fill_const(8'h00, 8'h00);
      ram_re[0] = 8'hFF;
      ram_im[0] = 8'hFF;
      ram_re[3] = 8'h01;
      run_frame("skipdc", 1'b0);

      // all-zero frame
      fill_const(8'h00, 8'h00);
      run_frame("zero", 1'b0);

      // randomized frames; small ranges make ties frequent
      for (int f = 0; f < 4; f++) begin
         if (f[0]) fill_random(255, 255);
         else      fill_random(3, 3);
         repeat ($urandom_range(0, 3)) @(negedge clock);
         run_frame($sformatf("rand%0d", f), 1'b0);
      end

      repeat (4) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
